// File: rtl/npc_mem_pkg.sv
// Shared definitions for the latency-modelled memory handshake masters.
// Holds the FSM encoding, the LFSR polynomial and the latency field width.
// No logic or latency of its own; it has no backpressure behaviour.
package npc_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // x^8 + x^6 + x^5 + x^4 + 1 in right-shifting Galois form
    localparam logic [7:0] LFSR_TAPS       = 8'hB8;
    localparam int         DEFAULT_TIMEOUT = 64;
    localparam int         LAT_W           = 5;
    localparam int         TCNT_W          = 10;

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {1'b0, s[7:1]} ^ (s[0] ? LFSR_TAPS : 8'h00);
    endfunction

endpackage

// File: rtl/lat_lfsr.sv
// 8-bit Galois LFSR used to pick random responder latencies.
// The state advances one step on the clock edge where step=1.
// Nothing to backpressure: it only advances when the owner asks it to.
module lat_lfsr
    import npc_mem_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       step,
    output logic [7:0] state
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED;
        end else if (step) begin
            state <= lfsr_step(state);
        end
    end

endmodule

// File: rtl/mem_req_initiator.sv
// Initiator for the latency-modelled memory handshake, one request in flight at a time.
// rsp_valid rises at least 2 cycles after accept; a REQ with no done aborts after TIMEOUT cycles.
// req_ready is low from accept until the cycle after the response handshake; rsp_* hold until rsp_ready.
module mem_req_initiator
    import npc_mem_pkg::*;
#(
    parameter int         ADDR_W    = 32,
    parameter int         DATA_W    = 32,
    parameter int         TIMEOUT   = DEFAULT_TIMEOUT,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic                  req_wen,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_wmask,
    input  logic                  rand_en,
    input  logic [LAT_W-1:0]      fixed_lat,

    output logic                  mem_req,
    output logic [LAT_W-1:0]      mem_times,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_wen,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wmask,
    input  logic                  mem_done,
    input  logic [DATA_W-1:0]     mem_rdata,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  spurious
);

    state_t            state;
    logic [TCNT_W-1:0] tcnt;
    logic [7:0]        lfsr_q;
    logic              accept;
    logic              timeout_hit;

    // Only the low bits pick a latency; the rest keep the sequence long.
    wire unused_lfsr_hi = ^lfsr_q[7:LAT_W];

    assign accept      = (state == ST_IDLE) && req_valid;
    assign timeout_hit = (tcnt == TCNT_W'(TIMEOUT - 1));

    lat_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lat_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (accept),
        .state (lfsr_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            tcnt      <= '0;
            req_ready <= 1'b1;
            mem_req   <= 1'b0;
            mem_times <= '0;
            mem_addr  <= '0;
            mem_wen   <= 1'b0;
            mem_wdata <= '0;
            mem_wmask <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            spurious  <= 1'b0;
        end else begin
            // Done outside REQ (including one arriving after a timeout) is never consumed.
            if (mem_done && (state != ST_REQ)) begin
                spurious <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        mem_addr  <= req_addr;
                        mem_wen   <= req_wen;
                        mem_wdata <= req_wdata;
                        mem_wmask <= req_wmask;
                        mem_times <= rand_en ? lfsr_q[LAT_W-1:0] : fixed_lat;
                        mem_req   <= 1'b1;
                        req_ready <= 1'b0;
                        tcnt      <= '0;
                        state     <= ST_REQ;
                    end
                end

                ST_REQ: begin
                    tcnt <= tcnt + 1'b1;
                    // Done is checked first so it wins a same-cycle timeout.
                    if (mem_done) begin
                        rsp_rdata <= mem_wen ? '0 : mem_rdata;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        mem_req   <= 1'b0;
                        state     <= ST_RESP;
                    end else if (timeout_hit) begin
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        mem_req   <= 1'b0;
                        state     <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_initiator.sv
// Directed bench for mem_req_initiator with a response scoreboard and an LFSR reference model.
module tb_mem_req_initiator;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_wen;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        rand_en;
    logic [4:0]  fixed_lat;
    logic        mem_req;
    logic [4:0]  mem_times;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        spurious;

    always #5 clk = ~clk;

    mem_req_initiator #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .TIMEOUT   (TO),
        .LFSR_SEED (8'hA5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_wen   (req_wen),
        .req_wdata (req_wdata),
        .req_wmask (req_wmask),
        .rand_en   (rand_en),
        .fixed_lat (fixed_lat),
        .mem_req   (mem_req),
        .mem_times (mem_times),
        .mem_addr  (mem_addr),
        .mem_wen   (mem_wen),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .mem_done  (mem_done),
        .mem_rdata (mem_rdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .spurious  (spurious)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [7:0]  model_lfsr;
    logic [4:0]  cur_times;
    logic [31:0] cur_wdata;
    logic [3:0]  cur_wmask;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference LFSR written from the polynomial: feedback into bits 7,5,4,3.
    function automatic logic [7:0] model_step(input logic [7:0] s);
        logic [7:0] n;
        logic       fb;
        fb = s[0];
        n  = s >> 1;
        if (fb) begin
            n[7] = ~n[7];
            n[5] = ~n[5];
            n[4] = ~n[4];
            n[3] = ~n[3];
        end
        return n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic w, input logic [31:0] wd,
                        input logic [3:0] wm, input logic [31:0] exp_rdata, input logic exp_err);
        int   n;
        rsp_t e;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("req_ready_before_accept", req_ready, 1);
        req_addr  = a;
        req_wen   = w;
        req_wdata = wd;
        req_wmask = wm;
        req_valid = 1'b1;
        cur_times = rand_en ? model_lfsr[4:0] : fixed_lat;
        cur_wdata = wd;
        cur_wmask = wm;
        model_lfsr = model_step(model_lfsr);
        e.rdata = exp_rdata;
        e.err   = exp_err;
        exp_q.push_back(e);
        tick();
        req_valid = 1'b0;
        req_addr  = ~a;
        req_wdata = ~wd;
        req_wmask = ~wm;
        check("mem_req_rise", mem_req, 1);
        check("req_ready_low", req_ready, 0);
        check("mem_times", mem_times, cur_times);
        check("mem_addr", mem_addr, a);
        check("mem_wen", mem_wen, w);
        check("mem_wdata", mem_wdata, wd);
        check("mem_wmask", mem_wmask, wm);
    endtask

    // Done is sampled in REQ cycle k (k=0 is the first REQ cycle).
    task automatic respond(input int k, input logic [31:0] d);
        for (int i = 0; i < k; i++) begin
            tick();
            check("mem_req_held", mem_req, 1);
            check("mem_times_held", mem_times, cur_times);
            check("mem_wdata_held", {mem_wdata, mem_wmask}, {cur_wdata, cur_wmask});
        end
        mem_done  = 1'b1;
        mem_rdata = d;
        tick();
        mem_done  = 1'b0;
        mem_rdata = $urandom;
        check("mem_req_drop", mem_req, 0);
    endtask

    task automatic collect(input int hold);
        int   n;
        rsp_t e;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        check("rsp_valid_seen", rsp_valid, 1);
        if (exp_q.size() == 0) begin
            check("scoreboard_nonempty", 0, 1);
            e = '0;
        end else begin
            e = exp_q.pop_front();
        end
        rsp_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            check("rsp_valid_hold", rsp_valid, 1);
            check("rsp_data_hold", {rsp_rdata, rsp_err}, {e.rdata, e.err});
            check("req_ready_in_resp", req_ready, 0);
            tick();
        end
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", rsp_err, e.err);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rsp_valid_clear", rsp_valid, 0);
        check("req_ready_after_hs", req_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] rd;
        rst_n = 1'b0;
        req_valid = 1'b0; req_addr = '0; req_wen = 1'b0; req_wdata = '0; req_wmask = '0;
        rand_en = 1'b0; fixed_lat = '0; mem_done = 1'b0; mem_rdata = '0; rsp_ready = 1'b0;
        model_lfsr = 8'hA5;
        #12;
        check("rst_req_ready", req_ready, 1);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_times", mem_times, 0);
        check("rst_mem_req_copy", {mem_addr, mem_wdata, mem_wmask, mem_wen}, 0);
        check("rst_rsp", {rsp_valid, rsp_rdata, rsp_err}, 0);
        check("rst_spurious", spurious, 0);
        rst_n = 1'b1;
        tick();

        // Random latencies straight from the seed, back to back.
        rand_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd = 32'h1000_0000 + i;
            send(32'h0000_1000 + 32'(i * 4), 1'b0, '0, 4'hF, rd, 1'b0);
            if (i == 0) check("rand_first_times", mem_times, 5'h05);
            respond(1, rd);
            collect(0);
        end

        // Fixed-latency read, done in the fourth REQ cycle.
        rand_en = 1'b0;
        fixed_lat = 5'd3;
        send(32'h8000_0000, 1'b0, '0, 4'hF, 32'hDEAD_BEEF, 1'b0);
        rand_en = 1'b1;
        respond(3, 32'hDEAD_BEEF);
        collect(0);
        rand_en = 1'b0;

        // Write with response backpressure; read data is ignored for writes.
        fixed_lat = 5'd0;
        send(32'h8000_0040, 1'b1, 32'h1234_5678, 4'b0011, 32'h0, 1'b0);
        respond(2, 32'hCAFE_F00D);
        collect(5);

        // Timeout, then a late done.
        send(32'h8000_0080, 1'b0, '0, 4'hF, 32'h0, 1'b1);
        n = 0;
        while (mem_req === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        check("timeout_req_cycles", n, TO);
        check("timeout_rsp_valid", rsp_valid, 1);
        check("spurious_before_late_done", spurious, 0);
        tick();
        tick();
        mem_done = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
        tick();
        mem_done = 1'b0;
        check("spurious_after_late_done", spurious, 1);
        collect(0);
        for (int i = 0; i < 4; i++) begin
            check("no_second_rsp", rsp_valid, 0);
            tick();
        end

        // Done lands on the last timeout cycle and wins.
        send(32'h8000_00C0, 1'b0, '0, 4'hF, 32'h5A5A_A5A5, 1'b0);
        respond(TO - 1, 32'h5A5A_A5A5);
        collect(0);

        // Reset while the request is outstanding.
        fixed_lat = 5'd9;
        send(32'h8000_0100, 1'b0, '0, 4'hF, 32'h0, 1'b0);
        tick();
        rst_n = 1'b0;
        #1;
        check("arst_mem_req", mem_req, 0);
        check("arst_rsp_valid", rsp_valid, 0);
        check("arst_spurious", spurious, 0);
        check("arst_req_ready", req_ready, 1);
        void'(exp_q.pop_back());
        model_lfsr = 8'hA5;
        #10;
        rst_n = 1'b1;
        tick();
        check("post_reset_idle", {rsp_valid, mem_req}, 0);
        rand_en = 1'b1;
        send(32'h8000_0200, 1'b0, '0, 4'hF, 32'h0BAD_CAFE, 1'b0);
        check("post_reset_rand_times", mem_times, 5'h05);
        respond(0, 32'h0BAD_CAFE);
        collect(2);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_req_initiator.md
Name: mem_req_initiator

Overview:
- Initiator side of the NPC latency-modelled memory handshake; sits between IFU/LSU request logic and the delay-based memory responder.
- Accepts one upstream request via valid/ready, drives the level-held downstream request with a chosen latency (fixed or LFSR-random), waits for the responder's done, and returns read data or a timeout error via valid/ready.
- Single outstanding transaction; no reordering.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (wmask is DATA_W/8)
- TIMEOUT, 64, cycles in REQ before abort; legal range 2..1023
- LFSR_SEED, 8'hA5, LFSR reset value; must be nonzero

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  upstream request valid
- req_ready  out  1  initiator can accept
- req_addr  in  ADDR_W  request address
- req_wen  in  1  1 = write, 0 = read
- req_wdata  in  DATA_W  write data
- req_wmask  in  DATA_W/8  byte write mask
- rand_en  in  1  1 = random latency, 0 = fixed
- fixed_lat  in  5  latency used when rand_en=0
- mem_req  out  1  downstream request, level-held until done or abort
- mem_times  out  5  latency requested from responder, stable while mem_req=1
- mem_addr / mem_wen / mem_wdata / mem_wmask  out  as upstream  registered copy of the accepted request
- mem_done  in  1  responder completion, 1-cycle pulse
- mem_rdata  in  DATA_W  valid in the cycle mem_done=1
- rsp_valid  out  1  response valid
- rsp_ready  in  1  upstream accepts response
- rsp_rdata  out  DATA_W  read data (0 for writes and timeouts)
- rsp_err  out  1  1 = timed out
- spurious  out  1  sticky: mem_done seen while mem_req=0

Behaviour:
- Reset values: req_ready=1, mem_req=0, mem_times=0, mem_addr/wdata/wmask/wen=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, spurious=0, lfsr=LFSR_SEED, tcnt=0, state=IDLE. Reset mid-transaction drops all state; no response is returned.
- FSM states are IDLE, REQ, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch the request and set mem_times = rand_en ? lfsr[4:0] : fixed_lat.
  - Step the LFSR: 8-bit Galois, taps x^8+x^6+x^5+x^4+1. It steps only on acceptance.
  - Set mem_req=1 and tcnt=0, then go to REQ. mem_req rises the cycle after the accept.
- REQ:
  - req_ready=0 and mem_req=1; all mem_* outputs are held stable.
  - tcnt increments each cycle.
  - If mem_done: capture rsp_rdata = mem_wen ? 0 : mem_rdata and rsp_err=0; mem_req drops next cycle; go to RESP.
  - Else if tcnt == TIMEOUT-1: rsp_err=1, rsp_rdata=0, drop mem_req, go to RESP.
  - If mem_done and the timeout fall in the same cycle, done wins (rsp_err=0).
- RESP:
  - rsp_valid=1, with rsp_* stable until rsp_ready.
  - On rsp_valid & rsp_ready, return to IDLE. req_ready becomes 1 the next cycle; there is no same-cycle turnaround.
- Minimum latency from accept to rsp_valid is 2 cycles, with mem_done in the first REQ cycle.
- mem_times=0 is legal; the responder defines its meaning. The initiator only waits for done.
- mem_done while state != REQ is ignored for data and sets spurious=1 until reset. This includes a late done arriving after a timeout.
- req_* changes while in REQ/RESP have no effect.

Decomposition:
- Shared package (npc_mem_pkg):
  - FSM state encoding (IDLE=0, REQ=1, RESP=2)
  - LFSR tap constant 8'hB8
  - default TIMEOUT constant
  - latency field width 5
- Sub-module lat_lfsr: 8-bit Galois LFSR with seed parameter, step enable, and 8-bit state output. It is reused by other latency-modelled bus masters.

Test Plan:
- Fixed read: rand_en=0, fixed_lat=3, read addr 0x8000_0000; responder pulses mem_done with rdata 0xDEADBEEF after 4 cycles -> mem_times=3 while mem_req=1; rsp_valid with rdata 0xDEADBEEF, rsp_err=0; mem_req low the cycle after done.
- Write with backpressure: wen=1, wdata 0x1234_5678, wmask 4'b0011; rsp_ready held low 5 cycles -> mem_wdata/wmask stable throughout REQ; rsp_valid stays 1 with rdata=0 for 5 cycles; req_ready=0 until the cycle after the handshake.
- Timeout: TIMEOUT=8, responder never answers -> mem_req high for exactly 8 cycles, then rsp_err=1, rsp_rdata=0. A mem_done injected 3 cycles later sets spurious=1 and produces no second rsp.
- Done/timeout collision: mem_done asserted on the cycle tcnt=TIMEOUT-1 -> rsp_err=0, rdata captured.
- Random latency: rand_en=1, seed 0xA5, 4 back-to-back reads -> mem_times matches the reference-model LFSR sequence (first value 0x05), advancing once per accepted request only.
- Reset mid-REQ: assert rst_n=0 while mem_req=1 -> mem_req, rsp_valid and spurious go 0 asynchronously; lfsr returns to 0xA5; the next request behaves as from fresh reset.
